// File: rtl/pwm_output_guard.sv
// Shoot-through and external-fault guard between the PWM generator and the gate drivers.
// Trips force every output low until software clears and the bus has stayed idle long enough.
module pwm_output_guard #(
    parameter int N_PAIRS      = 6,
    parameter int FILTER_WIDTH = 8,
    parameter int CLEAR_HOLD   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [2*N_PAIRS-1:0]    pwm_in,
    input  logic                    ext_fault,
    input  logic                    clear_fault,
    input  logic [FILTER_WIDTH-1:0] st_filter,
    output logic [2*N_PAIRS-1:0]    pwm_out,
    output logic                    tripped,
    output logic [1:0]              fault_state,
    output logic [N_PAIRS:0]        fault_source
);

    localparam int IW = $clog2(CLEAR_HOLD + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        TRIPPED  = 2'd1,
        CLEARING = 2'd2
    } state_t;

    state_t state, state_nx;

    logic                    ext_q1, ext_s;
    logic [FILTER_WIDTH-1:0] cnt    [N_PAIRS];
    logic [FILTER_WIDTH-1:0] cnt_nx [N_PAIRS];
    logic [N_PAIRS-1:0]      st;
    logic [FILTER_WIDTH:0]   thr;
    logic                    fault_now;
    logic [IW-1:0]           idle_cnt, idle_nx;
    logic [N_PAIRS:0]        src_nx;

    assign thr = (st_filter == '0) ? (FILTER_WIDTH+1)'(1) : {1'b0, st_filter};

    // cnt+1 is formed one bit wider so a saturated counter still compares correctly
    always_comb begin
        for (int k = 0; k < N_PAIRS; k++) begin
            logic both;
            logic [FILTER_WIDTH:0] inc;
            both = pwm_in[2*k] & pwm_in[2*k+1];
            inc  = {1'b0, cnt[k]} + (FILTER_WIDTH+1)'(1);
            st[k] = both && (inc >= thr);
            if (!both)
                cnt_nx[k] = '0;
            else if (&cnt[k])
                cnt_nx[k] = cnt[k];
            else
                cnt_nx[k] = inc[FILTER_WIDTH-1:0];
        end
    end

    assign fault_now = (|st) | ext_s;

    always_comb begin
        state_nx = state;
        idle_nx  = '0;
        src_nx   = fault_source;
        unique case (state)
            RUN: begin
                if (fault_now) begin
                    state_nx = TRIPPED;
                    src_nx   = {ext_s, st};
                end
            end
            TRIPPED: begin
                if (clear_fault && !fault_now)
                    state_nx = CLEARING;
            end
            CLEARING: begin
                if (fault_now) begin
                    state_nx = TRIPPED;
                    src_nx   = {ext_s, st};
                end else if (pwm_in == '0) begin
                    if (idle_cnt + IW'(1) >= IW'(CLEAR_HOLD)) begin
                        state_nx = RUN;
                        src_nx   = '0;
                    end else begin
                        idle_nx = idle_cnt + IW'(1);
                    end
                end
            end
            default: state_nx = CLEARING;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_q1       <= 1'b0;
            ext_s        <= 1'b0;
            state        <= CLEARING;
            tripped      <= 1'b1;
            idle_cnt     <= '0;
            fault_source <= '0;
            pwm_out      <= '0;
            for (int k = 0; k < N_PAIRS; k++)
                cnt[k] <= '0;
        end else begin
            ext_q1       <= ext_fault;
            ext_s        <= ext_q1;
            state        <= state_nx;
            tripped      <= (state_nx != RUN);
            idle_cnt     <= idle_nx;
            fault_source <= src_nx;
            pwm_out      <= (state_nx == RUN && enable) ? pwm_in : '0;
            for (int k = 0; k < N_PAIRS; k++)
                cnt[k] <= cnt_nx[k];
        end
    end

    assign fault_state = state;

endmodule
